// File: rtl/buyruk_pkg.sv
// Shared definitions for the buyruk_getir fetch stage.
//   BUYRUK_W   instruction width
//   ADR_W      program store address / pc width
//   DERINLIK   program store depth (2**ADR_W)
//   DUR_BUYRUK halt word; it is issued downstream, then the run ends
//   durum_t    sequencer states
package buyruk_pkg;

    localparam int BUYRUK_W = 9;
    localparam int ADR_W    = 4;
    localparam int DERINLIK = 2 ** ADR_W;

    localparam logic [BUYRUK_W-1:0] DUR_BUYRUK = 9'h1FF;

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        CALIS = 2'd1,
        BITTI = 2'd2
    } durum_t;

endpackage

// File: rtl/buyruk_bellegi.sv
// Program store: DERINLIK x BUYRUK_W words, synchronous write, combinational read.
// Contents have no reset, so a program survives rst_n.
//   clk       system clock
//   yaz_en    write enable (already qualified by the sequencer)
//   yaz_adr   write address
//   yaz_veri  write data
//   oku_adr   read address
//   oku_veri  read data (combinational)
module buyruk_bellegi
    import buyruk_pkg::*;
(
    input  logic                clk,
    input  logic                yaz_en,
    input  logic [ADR_W-1:0]    yaz_adr,
    input  logic [BUYRUK_W-1:0] yaz_veri,
    input  logic [ADR_W-1:0]    oku_adr,
    output logic [BUYRUK_W-1:0] oku_veri
);

    logic [BUYRUK_W-1:0] mem [DERINLIK];

    always_ff @(posedge clk) begin
        if (yaz_en) begin
            mem[yaz_adr] <= yaz_veri;
        end
    end

    assign oku_veri = mem[oku_adr];

endmodule

// File: rtl/buyruk_getir.sv
// Instruction fetch/sequencer feeding the execute unit. Loads a program through
// the write port while idle, then on calistir issues one word per non-stalled
// cycle until a halt word or the last address has been issued.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   BOSTA | idle; store writable, waits for calistir
//   CALIS | running; buyruk/pc valid, bekle holds the current word
//   BITTI | single end-of-run cycle with bitti=1, then back to BOSTA
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   yaz_en/adr/veri   program store write port (honoured only in BOSTA)
//   calistir          run request (sampled only in BOSTA)
//   bekle             downstream stall
//   buyruk, gecerli   issued instruction and its valid flag
//   basla             downstream start, high for the whole run
//   pc                address of the issued word
//   mesgul            high while running
//   bitti             one-cycle end-of-run pulse
module buyruk_getir
    import buyruk_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                yaz_en,
    input  logic [ADR_W-1:0]    yaz_adr,
    input  logic [BUYRUK_W-1:0] yaz_veri,
    input  logic                calistir,
    input  logic                bekle,
    output logic [BUYRUK_W-1:0] buyruk,
    output logic                gecerli,
    output logic                basla,
    output logic [ADR_W-1:0]    pc,
    output logic                mesgul,
    output logic                bitti
);

    durum_t              durum, durum_d;
    logic [BUYRUK_W-1:0] buyruk_d;
    logic [ADR_W-1:0]    pc_d;
    logic                gecerli_d, basla_d, mesgul_d, bitti_d;

    logic                bellek_yaz;
    logic [ADR_W-1:0]    oku_adr;
    logic [BUYRUK_W-1:0] oku_veri;
    logic                son;

    // A write coinciding with a run request is dropped so the run sees the old store.
    assign bellek_yaz = yaz_en && (durum == BOSTA) && !calistir;

    // Idle fetches address 0 for the first word; running fetches the next word.
    assign oku_adr = (durum == BOSTA) ? '0 : pc + ADR_W'(1);

    assign son = (buyruk == DUR_BUYRUK) || (pc == ADR_W'(DERINLIK - 1));

    buyruk_bellegi u_bellek (
        .clk      (clk),
        .yaz_en   (bellek_yaz),
        .yaz_adr  (yaz_adr),
        .yaz_veri (yaz_veri),
        .oku_adr  (oku_adr),
        .oku_veri (oku_veri)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            durum   <= BOSTA;
            buyruk  <= '0;
            gecerli <= 1'b0;
            basla   <= 1'b0;
            pc      <= '0;
            mesgul  <= 1'b0;
            bitti   <= 1'b0;
        end else begin
            durum   <= durum_d;
            buyruk  <= buyruk_d;
            gecerli <= gecerli_d;
            basla   <= basla_d;
            pc      <= pc_d;
            mesgul  <= mesgul_d;
            bitti   <= bitti_d;
        end
    end

    always_comb begin
        durum_d   = durum;
        buyruk_d  = buyruk;
        gecerli_d = gecerli;
        basla_d   = basla;
        pc_d      = pc;
        mesgul_d  = mesgul;
        bitti_d   = 1'b0;

        case (durum)
            BOSTA: begin
                if (calistir) begin
                    durum_d   = CALIS;
                    buyruk_d  = oku_veri;
                    pc_d      = '0;
                    gecerli_d = 1'b1;
                    basla_d   = 1'b1;
                    mesgul_d  = 1'b1;
                end
            end
            CALIS: begin
                if (!bekle) begin
                    if (son) begin
                        // pc keeps the last issued address through the BITTI cycle.
                        durum_d   = BITTI;
                        buyruk_d  = '0;
                        gecerli_d = 1'b0;
                        basla_d   = 1'b0;
                        mesgul_d  = 1'b0;
                        bitti_d   = 1'b1;
                    end else begin
                        buyruk_d = oku_veri;
                        pc_d     = pc + ADR_W'(1);
                    end
                end
            end
            BITTI: begin
                durum_d = BOSTA;
                pc_d    = '0;
            end
            default: begin
                durum_d   = BOSTA;
                buyruk_d  = '0;
                gecerli_d = 1'b0;
                basla_d   = 1'b0;
                pc_d      = '0;
                mesgul_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_buyruk_getir.sv
// Self-checking bench for buyruk_getir: a program model predicts the issued word
// sequence at each run start; a monitor compares every accepted word and the
// end-of-run pulse against that queue.
module tb_buyruk_getir;

    logic       clk;
    logic       rst_n;
    logic       yaz_en;
    logic [3:0] yaz_adr;
    logic [8:0] yaz_veri;
    logic       calistir;
    logic       bekle;
    logic [8:0] buyruk;
    logic       gecerli;
    logic       basla;
    logic [3:0] pc;
    logic       mesgul;
    logic       bitti;

    buyruk_getir dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .yaz_en   (yaz_en),
        .yaz_adr  (yaz_adr),
        .yaz_veri (yaz_veri),
        .calistir (calistir),
        .bekle    (bekle),
        .buyruk   (buyruk),
        .gecerli  (gecerli),
        .basla    (basla),
        .pc       (pc),
        .mesgul   (mesgul),
        .bitti    (bitti)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] b;
        logic [3:0] p;
        logic       son;
    } bek_t;

    bek_t       q[$];
    logic [8:0] mdl [16];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string ad, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", ad, act, exp, $time);
        end
    endtask

    // Program semantics: issue words from address 0 upward; the halt word is issued
    // too, and the run stops after it or after address 15. Then one end marker.
    task automatic push_run(output int nw);
        int son_pc;
        nw = 0;
        son_pc = 0;
        for (int i = 0; i < 16; i++) begin
            q.push_back('{b: mdl[i], p: 4'(i), son: 1'b0});
            nw++;
            son_pc = i;
            if (mdl[i] == 9'h1FF) break;
        end
        q.push_back('{b: 9'h000, p: 4'(son_pc), son: 1'b1});
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (gecerli) begin
                if (q.size() == 0) begin
                    chk("unexpected_word", 32'(buyruk), 32'h0);
                    chk("unexpected_word_valid", 32'(gecerli), 32'h0);
                end else begin
                    chk("word_buyruk", 32'(buyruk), 32'(q[0].b));
                    chk("word_pc", 32'(pc), 32'(q[0].p));
                    chk("word_not_end", 32'(q[0].son), 32'h0);
                    chk("word_basla", 32'(basla), 32'h1);
                    chk("word_mesgul", 32'(mesgul), 32'h1);
                    chk("word_bitti", 32'(bitti), 32'h0);
                    if (!bekle) void'(q.pop_front());
                end
            end
            if (bitti) begin
                if (q.size() == 0) begin
                    chk("unexpected_bitti", 32'(bitti), 32'h0);
                end else begin
                    chk("end_marker", 32'(q[0].son), 32'h1);
                    chk("end_pc", 32'(pc), 32'(q[0].p));
                    chk("end_buyruk", 32'(buyruk), 32'h0);
                    chk("end_gecerli", 32'(gecerli), 32'h0);
                    chk("end_basla", 32'(basla), 32'h0);
                    chk("end_mesgul", 32'(mesgul), 32'h0);
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic check_zero(input string ad);
        chk({ad, "_buyruk"}, 32'(buyruk), 32'h0);
        chk({ad, "_gecerli"}, 32'(gecerli), 32'h0);
        chk({ad, "_basla"}, 32'(basla), 32'h0);
        chk({ad, "_pc"}, 32'(pc), 32'h0);
        chk({ad, "_mesgul"}, 32'(mesgul), 32'h0);
        chk({ad, "_bitti"}, 32'(bitti), 32'h0);
    endtask

    task automatic yaz(input int adr, input logic [8:0] val);
        @(posedge clk); #1;
        yaz_en = 1'b1; yaz_adr = 4'(adr); yaz_veri = val;
        @(posedge clk); #1;
        yaz_en = 1'b0;
        mdl[adr] = val;
    endtask

    // stall_mode: 0 none, 1 random, 2 three cycles at pc=2
    task automatic run(input int stall_mode, input bit inject, input bit yazli, input bit rst_mode);
        int nw, gcnt, scnt;
        bit done;
        @(posedge clk); #1;
        push_run(nw);
        calistir = 1'b1;
        if (yazli) begin
            yaz_en = 1'b1; yaz_adr = 4'd0; yaz_veri = 9'h155;
        end
        @(posedge clk); #1;
        calistir = 1'b0; yaz_en = 1'b0; bekle = 1'b0;
        gcnt = 0; scnt = 0; done = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bitti) begin
                done = 1'b1;
                break;
            end
            if (gecerli) gcnt++;
            @(posedge clk); #1;
            yaz_en = 1'b0; calistir = 1'b0;
            if (rst_mode && gecerli && pc == 4'd5) begin
                #2 rst_n = 1'b0;
                #1 check_zero("midrun_reset");
                q.delete();
                bekle = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            case (stall_mode)
                1:       bekle = ($urandom_range(0, 3) == 0);
                2:       bekle = gecerli && (pc == 4'd2) && (scnt < 3);
                default: bekle = 1'b0;
            endcase
            if (bekle && gecerli) scnt++;
            if (inject && c == 3) begin
                yaz_en = 1'b1; yaz_adr = 4'd5; yaz_veri = 9'h0AA; calistir = 1'b1;
            end
        end
        bekle = 1'b0;
        chk("run_finished", 32'(done), 32'h1);
        chk("valid_cycles", 32'(gcnt), 32'(nw + scnt));
        if (stall_mode == 2) chk("stall_valid_cycles", 32'(gcnt), 32'(nw + 3));
        @(negedge clk);
        chk("idle_bitti", 32'(bitti), 32'h0);
        chk("idle_pc", 32'(pc), 32'h0);
        chk("idle_gecerli", 32'(gecerli), 32'h0);
        chk("queue_drained", 32'(q.size()), 32'h0);
        q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hp;
        rst_n = 1'b0; yaz_en = 1'b0; yaz_adr = '0; yaz_veri = '0;
        calistir = 1'b0; bekle = 1'b0;
        #2 check_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) yaz(i, 9'(i + 1));
        run(0, 1'b0, 1'b0, 1'b0);

        yaz(3, 9'h1FF);
        run(0, 1'b0, 1'b0, 1'b0);
        yaz(3, 9'h004);

        run(2, 1'b0, 1'b0, 1'b0);

        run(0, 1'b1, 1'b0, 1'b0);
        run(0, 1'b0, 1'b0, 1'b0);

        run(0, 1'b0, 1'b1, 1'b0);

        yaz(15, 9'h1FF);
        run(0, 1'b0, 1'b0, 1'b0);
        yaz(15, 9'h010);

        run(0, 1'b0, 1'b0, 1'b1);
        run(0, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 16; i++) yaz(i, 9'($urandom_range(0, 510)));
            if ($urandom_range(0, 1) == 1) begin
                hp = $urandom_range(0, 15);
                yaz(hp, 9'h1FF);
            end
            run(1, 1'b0, 1'b0, 1'b0);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
